// File: rtl/cplx_alu_seq.sv
// Command sequencer in front of the complex-number ALU: operand bank, load/operate commands,
// ALU start/done handshake with timeout, and result write-back/report.
module cplx_alu_seq #(
  parameter int ADDR_W  = 2,
  parameter int ALU_LAT = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_srcA,
  input  logic [ADDR_W-1:0] cmd_srcB,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [63:0]       cmd_data,
  output logic [63:0]       alu_inA,
  output logic [63:0]       alu_inB,
  output logic [3:0]        alu_opr,
  output logic              alu_start,
  input  logic [63:0]       alu_outAB,
  input  logic              alu_done,
  output logic              res_valid,
  output logic [63:0]       res_data,
  output logic              res_err,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       OP_MAX = 4'hA;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

  state_t              state_reg, state_next;
  logic [63:0]         bank_reg [DEPTH];
  logic [63:0]         alu_ina_reg, alu_inb_reg;
  logic [3:0]          alu_opr_reg;
  logic [ADDR_W-1:0]   dst_reg;
  logic [CNT_W-1:0]    wait_cnt_reg;
  logic [63:0]         res_data_reg;
  logic                res_err_reg;

  logic accept, op_legal, issue_done, issue_tmo;

  assign accept     = cmd_valid && (state_reg == ST_IDLE);
  assign op_legal   = (cmd_op <= OP_MAX);
  // done is only trusted once the minimum latency has elapsed, so a sticky flag cannot end an op early
  assign issue_done = (wait_cnt_reg >= LAT_M1) && alu_done;
  assign issue_tmo  = (wait_cnt_reg == TMO_M1);

  always_ff @(posedge clock) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && !cmd_load) state_next = op_legal ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        if (issue_done || issue_tmo) state_next = ST_RESP;
      end
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) bank_reg[i] <= '0;
      alu_ina_reg  <= '0;
      alu_inb_reg  <= '0;
      alu_opr_reg  <= '0;
      dst_reg      <= '0;
      wait_cnt_reg <= '0;
      res_data_reg <= '0;
      res_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_load) begin
              bank_reg[cmd_dst] <= cmd_data;
            end else if (op_legal) begin
              // operands are snapshotted here so a later write-back to srcA/srcB is harmless
              alu_ina_reg  <= bank_reg[cmd_srcA];
              alu_inb_reg  <= bank_reg[cmd_srcB];
              alu_opr_reg  <= cmd_op;
              dst_reg      <= cmd_dst;
              wait_cnt_reg <= '0;
            end else begin
              dst_reg      <= cmd_dst;
              res_data_reg <= '0;
              res_err_reg  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
          if (issue_done) begin
            res_data_reg <= alu_outAB;
            res_err_reg  <= 1'b0;
          end else if (issue_tmo) begin
            res_data_reg <= '0;
            res_err_reg  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (!res_err_reg) bank_reg[dst_reg] <= res_data_reg;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign alu_start = (state_reg == ST_ISSUE);
  assign res_valid = (state_reg == ST_RESP);
  assign alu_inA   = alu_ina_reg;
  assign alu_inB   = alu_inb_reg;
  assign alu_opr   = alu_opr_reg;
  assign res_data  = res_data_reg;
  assign res_err   = res_err_reg;

endmodule
